// File: rtl/zz_sched_pkg.sv
// rtl/zz_sched_pkg.sv - shared types and constants for the zigzag bank scheduler
//
// Purpose : reader FSM states, colour component codes, the coefficient bank
//           size, and the block-index to colour-component mapping.
// Ports   : none (package)
package zz_sched_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    COMP_Y  = 2'd0,
    COMP_CB = 2'd1,
    COMP_CR = 2'd2
  } comp_t;

  localparam int BLOCK_SIZE = 64;

  // 4:2:0 ordering: the first luma_blocks positions are Y, then one Cb,
  // and everything after that is Cr.
  function automatic comp_t comp_of(input logic [2:0] idx, input int luma_blocks);
    if (int'(idx) < luma_blocks)       return COMP_Y;
    else if (int'(idx) == luma_blocks) return COMP_CB;
    else                               return COMP_CR;
  endfunction

endpackage

// File: rtl/zz_watchdog.sv
// rtl/zz_watchdog.sv - scan-duration watchdog for the zigzag bank scheduler
//
// Purpose : counts consecutive cycles while 'active' is high and raises a
//           one-cycle 'timeout' on the LIMIT-th such cycle.
// Ports   : clk, rst_n (async, active-low)
//           clear   - synchronous counter clear
//           active  - count enable (scheduler is in SCAN)
//           timeout - high during the LIMIT-th active cycle
module zz_watchdog #(
  parameter int LIMIT = 127
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic active,
  output logic timeout
);

  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] cnt_q;

  // cnt_q holds the number of active cycles already completed, so it reads
  // LIMIT-1 during the LIMIT-th active cycle.
  assign timeout = active && (cnt_q == W'(LIMIT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear || !active || timeout) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + W'(1);
    end
  end

endmodule

// File: rtl/zz_bank_scheduler.sv
// rtl/zz_bank_scheduler.sv - ping-pong coefficient bank scheduler for the zigzag stage
//
// Purpose : steers the DCT coefficient stream into whichever of two 64-entry
//           banks is free, starts the zigzag scanner on a full bank when
//           downstream is ready, and tags each scanned block with its MCU
//           position and colour component.
// Ports   : clk, rst_n (async, active-low), frame_start (sync flush)
//           write side : in_valid, in_ready, wr_bank, wr_addr
//           read side  : out_ready, scan_start, scan_done, rd_bank,
//                        blk_idx, comp_id, mcu_last
//           status     : err_overflow, err_timeout (sticky)
// Config  : ZZ_SCHED_WATCHDOG_EN - adds the zz_watchdog scan timeout; when
//           undefined err_timeout is tied low and WATCHDOG_CYCLES is unused.
module zz_bank_scheduler
  import zz_sched_pkg::*;
#(
  parameter int BLOCKS_PER_MCU  = 6,
  parameter int LUMA_BLOCKS     = 4,
  parameter int WATCHDOG_CYCLES = 127
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_start,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       wr_bank,
  output logic [5:0] wr_addr,
  input  logic       out_ready,
  output logic       scan_start,
  input  logic       scan_done,
  output logic       rd_bank,
  output logic [2:0] blk_idx,
  output logic [1:0] comp_id,
  output logic       mcu_last,
  output logic       err_overflow,
  output logic       err_timeout
);

  localparam logic [5:0] LAST_ADDR = 6'(BLOCK_SIZE - 1);
  localparam logic [2:0] LAST_BLK  = 3'(BLOCKS_PER_MCU - 1);

  if (BLOCKS_PER_MCU < 1 || BLOCKS_PER_MCU > 8 ||
      LUMA_BLOCKS >= BLOCKS_PER_MCU || WATCHDOG_CYCLES < 1) begin : g_bad_params
    $error("zz_bank_scheduler: illegal parameter set");
  end

  state_t     state_q, state_d;
  logic [1:0] full_q, full_d;
  logic       wr_bank_q, rd_bank_q;
  logic [5:0] wr_cnt_q;
  logic [2:0] blk_idx_q;
  logic       scan_start_q;
  logic       err_overflow_q;

  logic       wr_fire, wr_last;
  logic       start_scan, release_bank;
  logic       wd_timeout;

  assign in_ready = !full_q[wr_bank_q];
  assign wr_fire  = in_valid && in_ready;
  assign wr_last  = wr_fire && (wr_cnt_q == LAST_ADDR);

  // Reader FSM: next state plus the start/release strobes.
  always_comb begin
    state_d      = state_q;
    start_scan   = 1'b0;
    release_bank = 1'b0;
    case (state_q)
      IDLE: begin
        if (full_q[rd_bank_q] && out_ready) begin
          start_scan = 1'b1;
          state_d    = SCAN;
        end
      end
      SCAN: begin
        if (scan_done || wd_timeout) begin
          release_bank = 1'b1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The writer only ever fills wr_bank and the reader only drains rd_bank,
  // and a bank is released before the writer can come back to it, so the
  // set and the clear never hit the same bit.
  always_comb begin
    full_d = full_q;
    if (wr_last)      full_d[wr_bank_q] = 1'b1;
    if (release_bank) full_d[rd_bank_q] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      full_q         <= 2'b00;
      wr_bank_q      <= 1'b0;
      rd_bank_q      <= 1'b0;
      wr_cnt_q       <= '0;
      blk_idx_q      <= '0;
      scan_start_q   <= 1'b0;
      err_overflow_q <= 1'b0;
    end else if (frame_start) begin
      state_q        <= IDLE;
      full_q         <= 2'b00;
      wr_bank_q      <= 1'b0;
      rd_bank_q      <= 1'b0;
      wr_cnt_q       <= '0;
      blk_idx_q      <= '0;
      scan_start_q   <= 1'b0;
      err_overflow_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      full_q       <= full_d;
      scan_start_q <= start_scan;
      if (wr_fire) begin
        wr_cnt_q <= wr_last ? 6'd0 : wr_cnt_q + 6'd1;
      end
      if (wr_last) begin
        wr_bank_q <= ~wr_bank_q;
      end
      if (release_bank) begin
        rd_bank_q <= ~rd_bank_q;
        blk_idx_q <= (blk_idx_q == LAST_BLK) ? 3'd0 : blk_idx_q + 3'd1;
      end
      if (in_valid && !in_ready) begin
        err_overflow_q <= 1'b1;
      end
    end
  end

`ifdef ZZ_SCHED_WATCHDOG_EN
  logic err_timeout_q;

  zz_watchdog #(
    .LIMIT (WATCHDOG_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (frame_start),
    .active  (state_q == SCAN),
    .timeout (wd_timeout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_timeout_q <= 1'b0;
    end else if (frame_start) begin
      err_timeout_q <= 1'b0;
    end else if (wd_timeout && !scan_done) begin
      err_timeout_q <= 1'b1;
    end
  end

  assign err_timeout = err_timeout_q;
`else
  assign wd_timeout  = 1'b0;
  assign err_timeout = 1'b0;
`endif

  assign wr_bank      = wr_bank_q;
  assign wr_addr      = wr_cnt_q;
  assign scan_start   = scan_start_q;
  assign rd_bank      = rd_bank_q;
  assign blk_idx      = blk_idx_q;
  assign comp_id      = comp_of(blk_idx_q, LUMA_BLOCKS);
  assign mcu_last     = (blk_idx_q == LAST_BLK);
  assign err_overflow = err_overflow_q;

endmodule

// File: tb/tb_zz_bank_scheduler.sv
// tb/tb_zz_bank_scheduler.sv - directed self-checking bench for zz_bank_scheduler
//
// Purpose : drives directed scenarios (reset, first block, full MCU sequence,
//           backpressure/overflow, same-cycle release and fill, frame flush,
//           watchdog) and compares outputs against hand-computed values.
// Ports   : none (top-level bench)
module tb_zz_bank_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       frame_start;
  logic       in_valid;
  logic       in_ready;
  logic       wr_bank;
  logic [5:0] wr_addr;
  logic       out_ready;
  logic       scan_start;
  logic       scan_done;
  logic       rd_bank;
  logic [2:0] blk_idx;
  logic [1:0] comp_id;
  logic       mcu_last;
  logic       err_overflow;
  logic       err_timeout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  zz_bank_scheduler #(
    .BLOCKS_PER_MCU  (6),
    .LUMA_BLOCKS     (4),
    .WATCHDOG_CYCLES (127)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .frame_start  (frame_start),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .wr_bank      (wr_bank),
    .wr_addr      (wr_addr),
    .out_ready    (out_ready),
    .scan_start   (scan_start),
    .scan_done    (scan_done),
    .rd_bank      (rd_bank),
    .blk_idx      (blk_idx),
    .comp_id      (comp_id),
    .mcu_last     (mcu_last),
    .err_overflow (err_overflow),
    .err_timeout  (err_timeout)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    frame_start = 1'b0;
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    scan_done   = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
  endtask

  // Outputs packed as {in_ready, wr_bank, wr_addr, scan_start, rd_bank,
  // blk_idx, comp_id, mcu_last, err_overflow, err_timeout}.
  task automatic test_reset();
    logic [17:0] obs;
    do_reset();
    rst_n = 1'b0;
    #1;
    obs = {in_ready, wr_bank, wr_addr, scan_start, rd_bank, blk_idx,
           comp_id, mcu_last, err_overflow, err_timeout};
    checks++;
    if (obs !== 18'b1_0_000000_0_0_000_00_0_0_0) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected %b", obs, 18'b1_0_000000_0_0_000_00_0_0_0);
    end
    step();
    rst_n = 1'b1;
    step();
    obs = {in_ready, wr_bank, wr_addr, scan_start, rd_bank, blk_idx,
           comp_id, mcu_last, err_overflow, err_timeout};
    checks++;
    if (obs !== 18'b1_0_000000_0_0_000_00_0_0_0) begin
      errors++;
      $display("FAIL post_reset_outputs: got %b expected %b", obs, 18'b1_0_000000_0_0_000_00_0_0_0);
    end
  endtask

  task automatic test_first_block();
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 64; i++) begin
      in_valid = 1'b1;
      checks++;
      if (wr_addr !== 6'(i) || wr_bank !== 1'b0 || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL first_wr_addr[%0d]: got addr=%0d bank=%0d rdy=%0d expected addr=%0d bank=0 rdy=1",
                 i, wr_addr, wr_bank, in_ready, i);
      end
      step();
    end
    in_valid = 1'b0;
    checks++;
    if (wr_bank !== 1'b1 || wr_addr !== 6'd0 || scan_start !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL first_after_last: got bank=%0d addr=%0d start=%0d rdy=%0d expected 1 0 0 1",
               wr_bank, wr_addr, scan_start, in_ready);
    end
    step();
    checks++;
    if (scan_start !== 1'b1 || rd_bank !== 1'b0 || blk_idx !== 3'd0 ||
        comp_id !== 2'd0 || mcu_last !== 1'b0) begin
      errors++;
      $display("FAIL first_scan_start: got start=%0d rd=%0d blk=%0d comp=%0d last=%0d expected 1 0 0 0 0",
               scan_start, rd_bank, blk_idx, comp_id, mcu_last);
    end
    step();
    checks++;
    if (scan_start !== 1'b0 || blk_idx !== 3'd0) begin
      errors++;
      $display("FAIL first_scan_pulse: got start=%0d blk=%0d expected 0 0", scan_start, blk_idx);
    end
  endtask

  // Input every cycle; scanner finishes 62 cycles after each scan_start so
  // each scan_start lands 64 cycles after the previous one with no stall.
  task automatic test_mcu_sequence();
    int exp_comp[6] = '{0, 0, 0, 0, 1, 2};
    int cyc   = 0;
    int k     = 0;
    int sd_at = -1;
    int e;
    do_reset();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    while (k < 7 && cyc < 1000) begin
      scan_done = (cyc == sd_at);
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL mcu_in_ready[c%0d]: got %0d expected 1", cyc, in_ready);
      end
      if (scan_start === 1'b1) begin
        e = k % 6;
        checks++;
        if (cyc != 65 + 64 * k) begin
          errors++;
          $display("FAIL mcu_start_cycle[%0d]: got %0d expected %0d", k, cyc, 65 + 64 * k);
        end
        checks++;
        if (blk_idx !== 3'(e) || comp_id !== 2'(exp_comp[e]) || mcu_last !== (e == 5)) begin
          errors++;
          $display("FAIL mcu_tags[%0d]: got blk=%0d comp=%0d last=%0d expected %0d %0d %0d",
                   k, blk_idx, comp_id, mcu_last, e, exp_comp[e], (e == 5));
        end
        sd_at = cyc + 62;
        k++;
      end
      step();
      cyc++;
    end
    scan_done = 1'b0;
    in_valid  = 1'b0;
    checks++;
    if (k < 7) begin
      errors++;
      $display("FAIL mcu_scan_count: got %0d expected 7", k);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    repeat (128) step();
    checks++;
    if (in_ready !== 1'b0 || wr_bank !== 1'b0 || wr_addr !== 6'd0 || err_overflow !== 1'b0) begin
      errors++;
      $display("FAIL bp_both_full: got rdy=%0d bank=%0d addr=%0d ovf=%0d expected 0 0 0 0",
               in_ready, wr_bank, wr_addr, err_overflow);
    end
    step();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (err_overflow !== 1'b1 || wr_addr !== 6'd0 || scan_start !== 1'b0) begin
      errors++;
      $display("FAIL bp_overflow: got ovf=%0d addr=%0d start=%0d expected 1 0 0",
               err_overflow, wr_addr, scan_start);
    end
    step();
    checks++;
    if (scan_start !== 1'b1 || rd_bank !== 1'b0 || err_overflow !== 1'b1) begin
      errors++;
      $display("FAIL bp_release_scan: got start=%0d rd=%0d ovf=%0d expected 1 0 1",
               scan_start, rd_bank, err_overflow);
    end
    step();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    checks++;
    if (err_overflow !== 1'b0 || in_ready !== 1'b1 || wr_bank !== 1'b0 || scan_start !== 1'b0) begin
      errors++;
      $display("FAIL bp_flush: got ovf=%0d rdy=%0d bank=%0d start=%0d expected 0 1 0 0",
               err_overflow, in_ready, wr_bank, scan_start);
    end
    step();
    checks++;
    if (scan_start !== 1'b0) begin
      errors++;
      $display("FAIL bp_flush_no_scan: got %0d expected 0", scan_start);
    end
  endtask

  task automatic test_same_cycle();
    do_reset();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    repeat (127) step();
    scan_done = 1'b1;
    step();
    scan_done = 1'b0;
    in_valid  = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || wr_bank !== 1'b0 || rd_bank !== 1'b1 ||
        blk_idx !== 3'd1 || scan_start !== 1'b0) begin
      errors++;
      $display("FAIL same_cycle_state: got rdy=%0d wb=%0d rb=%0d blk=%0d start=%0d expected 1 0 1 1 0",
               in_ready, wr_bank, rd_bank, blk_idx, scan_start);
    end
    step();
    checks++;
    if (scan_start !== 1'b1 || rd_bank !== 1'b1 || blk_idx !== 3'd1) begin
      errors++;
      $display("FAIL same_cycle_bank1_scan: got start=%0d rb=%0d blk=%0d expected 1 1 1",
               scan_start, rd_bank, blk_idx);
    end
  endtask

  task automatic test_frame_start();
    do_reset();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    repeat (96) step();
    checks++;
    if (wr_addr !== 6'd32 || wr_bank !== 1'b1) begin
      errors++;
      $display("FAIL fs_half_written: got addr=%0d bank=%0d expected 32 1", wr_addr, wr_bank);
    end
    frame_start = 1'b1;
    scan_done   = 1'b1;
    step();
    frame_start = 1'b0;
    in_valid    = 1'b0;
    checks++;
    if (wr_addr !== 6'd0 || wr_bank !== 1'b0 || rd_bank !== 1'b0 || blk_idx !== 3'd0 ||
        in_ready !== 1'b1 || scan_start !== 1'b0) begin
      errors++;
      $display("FAIL fs_flushed: got addr=%0d wb=%0d rb=%0d blk=%0d rdy=%0d start=%0d expected 0 0 0 0 1 0",
               wr_addr, wr_bank, rd_bank, blk_idx, in_ready, scan_start);
    end
    step();
    scan_done = 1'b0;
    checks++;
    if (blk_idx !== 3'd0 || rd_bank !== 1'b0 || scan_start !== 1'b0) begin
      errors++;
      $display("FAIL fs_late_done_ignored: got blk=%0d rb=%0d start=%0d expected 0 0 0",
               blk_idx, rd_bank, scan_start);
    end
  endtask

  task automatic test_watchdog();
    do_reset();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    repeat (64) step();
    in_valid = 1'b0;
    repeat (127) step();
    checks++;
    if (err_timeout !== 1'b0 || blk_idx !== 3'd0) begin
      errors++;
      $display("FAIL wd_before: got to=%0d blk=%0d expected 0 0", err_timeout, blk_idx);
    end
    step();
`ifdef ZZ_SCHED_WATCHDOG_EN
    checks++;
    if (err_timeout !== 1'b1 || blk_idx !== 3'd1 || rd_bank !== 1'b1 || scan_start !== 1'b0) begin
      errors++;
      $display("FAIL wd_fired: got to=%0d blk=%0d rb=%0d start=%0d expected 1 1 1 0",
               err_timeout, blk_idx, rd_bank, scan_start);
    end
`else
    repeat (50) step();
    checks++;
    if (err_timeout !== 1'b0 || blk_idx !== 3'd0 || rd_bank !== 1'b0 || scan_start !== 1'b0) begin
      errors++;
      $display("FAIL wd_absent: got to=%0d blk=%0d rb=%0d start=%0d expected 0 0 0 0",
               err_timeout, blk_idx, rd_bank, scan_start);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_first_block();
    test_mcu_sequence();
    test_backpressure();
    test_same_cycle();
    test_frame_start();
    test_watchdog();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
